// File: rtl/phy_pkg.sv
// phy_pkg: shared constants and state encoding for the PHY transmit path.
package phy_pkg;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hBC;
  localparam int LANES = 4;
  localparam int BYTE_W = 8;
  localparam int FRAME_LEN = 32;
  typedef enum logic {SYNC, ACTIVE} state_e;
endpackage

// File: rtl/tx_piso8.sv
// tx_piso8: 8-bit parallel-load shift register, MSB shifted out first.
module tx_piso8 import phy_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] d_i,
  output logic              q_o
);
  logic [BYTE_W-1:0] sr_q, sr_d;
  always_comb sr_d = load_i ? d_i : {sr_q[BYTE_W-2:0], 1'b0};
  always_ff @(posedge clk) sr_q <= !rst ? '0 : sr_d;
  assign q_o = sr_q[BYTE_W-1];
endmodule

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: four byte lanes serialized into 32-cycle frames, MSB first,
// with idle fill for invalid lanes and an all-idle sync period after reset.
module phy_tx_serializer import phy_pkg::*; #(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF,
  parameter int SYNC_FRAMES = 1
) (
  input  logic              clk_32f,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in0,
  input  logic [BYTE_W-1:0] in1,
  input  logic [BYTE_W-1:0] in2,
  input  logic [BYTE_W-1:0] in3,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  output logic              serial_out,
  output logic              ready,
  output logic              frame_start
);
  logic [4:0] cnt_q, cnt_d;
  state_e st_q, st_d;
  logic [7:0] frm_q, frm_d;
  logic first_q, fs_q, wrap, take, load;
  logic [LANES-1:0][BYTE_W-1:0] hold_q, hold_d, din;
  logic [LANES-1:0] vin;
  always_comb begin
    din = {in3, in2, in1, in0};
    vin = {valid3, valid2, valid1, valid0};
    wrap = cnt_q == 5'd31;
    cnt_d = first_q ? 5'd0 : cnt_q + 5'd1;
    take = wrap && (st_q == ACTIVE || frm_q == 8'(SYNC_FRAMES - 1));
    st_d = take ? ACTIVE : st_q;
    frm_d = (st_q == SYNC && wrap) ? frm_q + 8'd1 : frm_q;
    for (int i = 0; i < LANES; i++)
      hold_d[i] = take ? (vin[i] ? din[i] : IDLE_BYTE) : hold_q[i];
    load = first_q || cnt_q[2:0] == 3'd7;
  end
  // The reset-exit edge holds cnt at 0 so the first visible bit aligns with slot 0.
  always_ff @(posedge clk_32f) begin
    if (!rst) begin
      cnt_q <= '0;
      st_q <= SYNC;
      frm_q <= '0;
      first_q <= 1'b1;
      fs_q <= 1'b0;
      hold_q <= {LANES{IDLE_BYTE}};
    end else begin
      cnt_q <= cnt_d;
      st_q <= st_d;
      frm_q <= frm_d;
      first_q <= 1'b0;
      fs_q <= cnt_d == 5'd0;
      hold_q <= hold_d;
    end
  end
  tx_piso8 u_piso (
    .clk(clk_32f),
    .rst(rst),
    .load_i(load),
    .d_i(hold_d[cnt_d[4:3]]),
    .q_o(serial_out)
  );
  assign ready = st_q == ACTIVE;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_phy_tx_serializer.sv
// tb_phy_tx_serializer: directed frame vectors plus reset and sync corner cases.
module tb_phy_tx_serializer;
  logic clk_32f = 0, rst = 0;
  logic [7:0] in0 = 0, in1 = 0, in2 = 0, in3 = 0;
  logic valid0 = 0, valid1 = 0, valid2 = 0, valid3 = 0;
  logic serial_out, ready, frame_start;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[7];

  phy_tx_serializer dut (
    .clk_32f(clk_32f), .rst(rst),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .serial_out(serial_out), .ready(ready), .frame_start(frame_start)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] v);
    {in0, in1, in2, in3} = d;
    {valid3, valid2, valid1, valid0} = v;
  endtask

  task automatic run_frame(input string n, input logic [31:0] d, input logic [3:0] v,
                           input logic [31:0] exp, input logic rdy_exp, input bit idle_feed);
    logic [31:0] got;
    logic fs_bad, rdy_bad;
    got = 0; fs_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_32f);
      got = {got[30:0], serial_out};
      if (frame_start !== (i == 0)) fs_bad = 1;
      if (ready !== rdy_exp) rdy_bad = 1;
      if (i == 31) drive(d, v);
      else if (idle_feed) drive(32'hBCBCBCBC, 4'hF);
      else drive($urandom, 4'($urandom));
    end
    check({n, " bits"}, got, exp);
    check({n, " frame_start"}, fs_bad, 0);
    check({n, " ready"}, rdy_bad, 0);
  endtask

  initial begin
    logic rst_bad;
    tbl[0] = '{32'h01020304, 4'b1111, 32'h01020304};
    tbl[1] = '{32'hFFFFA5FF, 4'b0100, 32'hBCBCA5BC};
    tbl[2] = '{32'h3C3C3C3C, 4'b1111, 32'h3C3C3C3C};
    tbl[3] = '{32'hBC00BCFF, 4'b1111, 32'hBC00BCFF};
    tbl[4] = '{32'h80017EC3, 4'b0101, 32'h80BC7EBC};
    tbl[5] = '{32'hAAAAAAAA, 4'b0000, 32'hBCBCBCBC};
    tbl[6] = '{32'hFF00FF00, 4'b1010, 32'hBC00BC00};
    repeat (3) @(negedge clk_32f);
    check("reset serial_out", serial_out, 0);
    check("reset ready", ready, 0);
    check("reset frame_start", frame_start, 0);
    rst = 1;
    run_frame("sync", tbl[0].d, tbl[0].v, 32'hBCBCBCBC, 0, 0);
    for (int k = 0; k < 7; k++)
      run_frame($sformatf("vec%0d", k), k < 6 ? tbl[k+1].d : 32'h0, k < 6 ? tbl[k+1].v : 4'h0,
                tbl[k].exp, 1, 0);
    repeat (14) @(negedge clk_32f);
    check("mid-frame ready", ready, 1);
    check("mid-frame bit cnt13", serial_out, 1);
    rst = 0;
    rst_bad = 0;
    repeat (2) begin
      @(negedge clk_32f);
      if (serial_out !== 0 || ready !== 0 || frame_start !== 0) rst_bad = 1;
    end
    check("mid-frame reset outputs", rst_bad, 0);
    rst = 1;
    run_frame("resync", 32'h01FFFFFF, 4'b0001, 32'hBCBCBCBC, 0, 1);
    run_frame("post-resync", 32'h0, 4'h0, 32'h01BCBCBC, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
